// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ps2_pkg
// Brief   : Shared PS/2 definitions for the device transmitter and the host
//           receiver: FSM states, frame layout constants and the parity helper.
// Revision: 1.0 - initial release
// ============================================================================
package ps2_pkg;

  // Explicitly encoded two-bit state type shared by both PS/2 ends
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_LOW   = 2'd2,
    ST_GAP   = 2'd3
  } ps2_state_e;

  // start + 8 data + parity + stop
  localparam int   FRAME_BITS = 11;
  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;

  // Parity bit that makes data plus parity carry an odd number of ones
  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_dev_tx_if.sv
`default_nettype none
// ============================================================================
// Module  : ps2_dev_tx_if
// Brief   : Byte-offer handshake between a scan-code source and the PS/2
//           device transmitter (valid/ready, one byte per accepted beat).
// Revision: 1.0 - initial release
// ============================================================================
interface ps2_dev_tx_if;

  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  // Byte source side
  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

  // Transmitter side
  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );

endinterface
`default_nettype wire

// File: rtl/ps2_sync.sv
`default_nettype none
// ============================================================================
// Module  : ps2_sync
// Brief   : Two-flop synchroniser for an asynchronous PS/2 line. Resets to the
//           released (high) level so nothing looks like a host inhibit.
// Revision: 1.0 - initial release
// ============================================================================
module ps2_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic r_meta;
  logic r_sync;

  // Two-stage resynchronisation of the line into the clk domain
  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
    end
  end

  assign q = r_sync;

endmodule
`default_nettype wire

// File: rtl/ps2_dev_tx.sv
`default_nettype none
// ============================================================================
// Module  : ps2_dev_tx
// Brief   : PS/2 device-side (keyboard) transmitter. Serialises one byte into
//           an 11-bit frame on open-drain clock/data lines, honours host
//           inhibit during the clock-released phase and enforces an idle gap
//           between frames.
// Revision: 1.0 - initial release
// ============================================================================
module ps2_dev_tx
  import ps2_pkg::*;
#(
  parameter int HALF_PER = 4000,
  parameter int GAP_CYC  = 8000,
  parameter int CNT_W    = 16
) (
  input  logic           clk,
  input  logic           rst,
  ps2_dev_tx_if.slave    tx,
  input  logic           ps2_clk_i,
  output logic           ps2_clk_oe,
  output logic           ps2_data_oe,
  output logic           busy,
  output logic           abort
);

  localparam logic [CNT_W-1:0] c_half_last   = CNT_W'(HALF_PER - 1);
  localparam logic [CNT_W-1:0] c_gap_last    = CNT_W'(GAP_CYC - 1);
  localparam logic [CNT_W-1:0] c_inhibit_min = CNT_W'(2);
  localparam logic [CNT_W-1:0] c_cnt_one     = CNT_W'(1);
  localparam logic [3:0]       c_last_bit    = 4'(FRAME_BITS - 1);

  ps2_state_e              r_state;
  ps2_state_e              w_state_nxt;
  logic [CNT_W-1:0]        r_cnt;
  logic [CNT_W-1:0]        w_cnt_nxt;
  logic [3:0]              r_bit_idx;
  logic [3:0]              w_bit_idx_nxt;
  logic [FRAME_BITS-1:0]   r_shift;
  logic [FRAME_BITS-1:0]   w_shift_nxt;
  logic                    r_ready_en;
  logic                    w_clk_s;
  logic                    w_ready;

  ps2_sync #(
    .RST_VAL (1'b1)
  ) u_clk_sync (
    .clk (clk),
    .rst (rst),
    .d   (ps2_clk_i),
    .q   (w_clk_s)
  );

  // Holds tx_ready low while reset is asserted; opens the handshake afterwards
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ready_en <= 1'b0;
    end else begin
      r_ready_en <= 1'b1;
    end
  end

  // State, phase/gap counter, bit index and frame shift register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_bit_idx <= w_bit_idx_nxt;
      r_shift   <= w_shift_nxt;
    end
  end

  // Next-state logic and line drive; data line drives the inverse of the bit
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_bit_idx_nxt = r_bit_idx;
    w_shift_nxt   = r_shift;
    w_ready       = 1'b0;
    ps2_clk_oe    = 1'b0;
    ps2_data_oe   = 1'b0;
    busy          = 1'b0;
    abort         = 1'b0;

    case (r_state)
      ST_IDLE: begin
        // A host holding the clock low blocks acceptance
        w_ready = w_clk_s & r_ready_en;
        if (tx.tx_valid && w_ready) begin
          w_shift_nxt   = {STOP_BIT, odd_parity(tx.tx_data), tx.tx_data, START_BIT};
          w_bit_idx_nxt = '0;
          w_cnt_nxt     = '0;
          w_state_nxt   = ST_SETUP;
        end
      end

      ST_SETUP: begin
        busy        = 1'b1;
        ps2_data_oe = ~r_shift[0];
        // The first two counts still see our own clock-low through the
        // synchroniser, so only later counts can detect a host inhibit
        if ((r_cnt >= c_inhibit_min) && !w_clk_s) begin
          abort       = 1'b1;
          ps2_data_oe = 1'b0;
          w_cnt_nxt   = '0;
          w_state_nxt = ST_GAP;
        end else if (r_cnt == c_half_last) begin
          w_cnt_nxt   = '0;
          w_state_nxt = ST_LOW;
        end else begin
          w_cnt_nxt = r_cnt + c_cnt_one;
        end
      end

      ST_LOW: begin
        busy        = 1'b1;
        ps2_clk_oe  = 1'b1;
        ps2_data_oe = ~r_shift[0];
        if (r_cnt == c_half_last) begin
          w_cnt_nxt = '0;
          if (r_bit_idx == c_last_bit) begin
            w_state_nxt = ST_GAP;
          end else begin
            w_shift_nxt   = r_shift >> 1;
            w_bit_idx_nxt = r_bit_idx + 4'd1;
            w_state_nxt   = ST_SETUP;
          end
        end else begin
          w_cnt_nxt = r_cnt + c_cnt_one;
        end
      end

      ST_GAP: begin
        busy = 1'b1;
        if (r_cnt == c_gap_last) begin
          w_cnt_nxt   = '0;
          w_state_nxt = ST_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + c_cnt_one;
        end
      end

      default: begin
        w_cnt_nxt   = '0;
        w_state_nxt = ST_IDLE;
      end
    endcase

    tx.tx_ready = w_ready;
  end

endmodule
`default_nettype wire
